// File: rtl/irq_pending_ctrl_pkg.sv
// ============================================================================
// Module  : irq_pending_ctrl_pkg
// Brief   : Shared sizes and FSM state encodings for the interrupt pending controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_pending_ctrl_pkg;

  localparam int N_SRC = 4;
  localparam int ID_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/irq_edge_detect.sv
// ============================================================================
// Module  : irq_edge_detect
// Brief   : Per-source set generation, rising-edge or level depending on EDGE_MODE.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_edge_detect
  import irq_pending_ctrl_pkg::*;
#(
  parameter int EDGE_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  output logic [N_SRC-1:0] irq_set
);

  logic [N_SRC-1:0] prev_irq_d;
  logic [N_SRC-1:0] prev_irq_q;

  always_comb begin
    prev_irq_d = irq_in;
  end

  // Clearing to zero on reset makes a line held high across reset release look like a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_irq_q <= '0;
    end else begin
      prev_irq_q <= prev_irq_d;
    end
  end

  generate
    if (EDGE_MODE != 0) begin : g_edge
      assign irq_set = irq_in & ~prev_irq_q;
    end else begin : g_level
      assign irq_set = irq_in;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/irq_pending_ctrl.sv
// ============================================================================
// Module  : irq_pending_ctrl
// Brief   : Pending-flag interrupt controller with fixed priority and ack handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
#(
  parameter int EDGE_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] mask,
  input  logic             ack,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending
);

  state_e           state_d,     state_q;
  logic [N_SRC-1:0] pending_d,   pending_q;
  logic [ID_W-1:0]  irq_id_d,    irq_id_q;
  logic             irq_valid_d, irq_valid_q;

  logic [N_SRC-1:0] irq_set;
  logic [N_SRC-1:0] enabled;
  logic             sel_any;
  logic [ID_W-1:0]  sel_id;
  logic [N_SRC-1:0] clr;

  irq_edge_detect #(
    .EDGE_MODE (EDGE_MODE)
  ) u_edge (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_in),
    .irq_set (irq_set)
  );

  // Ascending scan so the highest enabled index is the last one written.
  always_comb begin
    enabled = pending_q & mask;
    sel_any = |enabled;
    sel_id  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (enabled[i]) begin
        sel_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    irq_id_d    = irq_id_q;
    irq_valid_d = irq_valid_q;
    clr         = '0;
    case (state_q)
      IDLE: begin
        irq_valid_d = 1'b0;
        if (sel_any) begin
          irq_id_d    = sel_id;
          irq_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          clr         = N_SRC'(1) << irq_id_q;
          irq_valid_d = 1'b0;
          state_d     = GAP;
        end
      end
      GAP: begin
        irq_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        irq_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    // New sets are ORed after the clear so a coincident set survives the ack.
    pending_d = (pending_q & ~clr) | irq_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      irq_id_q    <= '0;
      irq_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      irq_id_q    <= irq_id_d;
      irq_valid_q <= irq_valid_d;
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;

endmodule

`default_nettype wire
